switch_port_rx: RTL and testbench

// Receive side of one switch input port. Consumes the per-port byte stream (data + status)

---
 rtl/switch_pkg.sv | 16 +
 rtl/switch_desc_fifo.sv | 44 ++++
 rtl/switch_port_rx.sv | 213 +++++++++++++++++++++
 tb/tb_switch_port_rx.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared types for the switch input port: FSM state encodings and the committed-packet descriptor.
package switch_pkg;

    localparam int unsigned PKT_HDR_BYTES = 3;
    localparam int unsigned PORT_W        = 4;
    localparam int unsigned TOTAL_W       = 9;

    typedef enum logic [2:0] {RxIdle, RxSa, RxLen, RxPay, RxDrop} rx_state_e;
    typedef enum logic [1:0] {TxIdle, TxReq, TxSend} tx_state_e;

    typedef struct packed {
        logic [PORT_W-1:0]  port;
        logic [TOTAL_W-1:0] total;
    } desc_t;

endpackage

// File: rtl/switch_desc_fifo.sv
// Synchronous FIFO of committed-packet descriptors; head entry is visible combinationally.
module switch_desc_fifo
    import switch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  desc_t                  wdata,
    input  logic                   pop,
    output desc_t                  rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = (AW+1)'(1);
    localparam logic [AW:0] DepthC = (AW+1)'(DEPTH);

    desc_t       mem_q [DEPTH];
    logic [AW:0] wr_q;
    logic [AW:0] rd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push && !full) wr_q <= wr_q + PtrOne;
            if (pop && !empty) rd_q <= rd_q + PtrOne;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem_q[wr_q[AW-1:0]] <= wdata;
    end

    assign count = wr_q - rd_q;
    assign full  = (count == DepthC);
    assign empty = (count == '0);
    assign rdata = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/switch_port_rx.sv
// Switch input port receive side: parses, validates and stores packets (store-and-forward),
// then offers each committed packet to the crossbar with a req/grant handshake.
module switch_port_rx
    import switch_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = PORT_W,
    parameter int unsigned MAX_PAY    = 32,
    parameter int unsigned BUF_DEPTH  = 128,
    parameter int unsigned DESC_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             in_data,
    input  logic                   in_status,
    output logic                   in_busy,
    input  logic [NUM_PORTS*8-1:0] port_addr,
    output logic                   out_req,
    output logic [NUM_PORTS-1:0]   out_port,
    input  logic                   out_grant,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    output logic                   out_last,
    output logic [15:0]            ok_cnt,
    output logic [15:0]            drop_cnt
);
    localparam int unsigned PW  = $clog2(BUF_DEPTH);
    localparam int unsigned DCW = $clog2(DESC_DEPTH) + 1;
    localparam logic [PW-1:0] PtrOne = PW'(1);

    logic [7:0]           mem_q [BUF_DEPTH];
    logic [PW-1:0]        wr_ptr_q, tent_ptr_q, rd_ptr_q, free_bytes;
    rx_state_e            rx_state_q, rx_state_d;
    tx_state_e            tx_state_q, tx_state_d;
    logic [7:0]           len_q, pay_cnt_q;
    logic [NUM_PORTS-1:0] port_q, da_port;
    logic [15:0]          ok_cnt_q, drop_cnt_q;
    logic                 busy_q, byte_we, commit, drop, space, len_bad;
    logic [TOTAL_W-1:0]   tx_off_q;
    logic [7:0]           out_data_q;
    logic                 out_valid_q, out_last_q, tx_start, tx_last;
    desc_t                desc_wdata, desc_head;
    logic                 desc_push, desc_pop, desc_full, desc_empty;
    logic [DCW-1:0]       desc_count;

    // Lowest matching index wins: scan downward so the lowest match is written last.
    always_comb begin
        da_port = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (in_data == port_addr[8*i +: 8]) da_port = NUM_PORTS'(1) << i;
        end
    end

    // The slot just before rd_ptr stays empty so full and empty are distinguishable.
    assign space      = (tent_ptr_q + PtrOne) != rd_ptr_q;
    assign free_bytes = rd_ptr_q - wr_ptr_q - PtrOne;
    assign len_bad    = (in_data == 8'd0) || (32'(in_data) > MAX_PAY);

    always_ff @(posedge clk) begin
        if (rst) rx_state_q <= RxDrop;
        else     rx_state_q <= rx_state_d;
    end

    always_comb begin
        byte_we = 1'b0;
        commit  = 1'b0;
        drop    = 1'b0;
        unique case (rx_state_q)
            RxIdle: if (in_status) begin
                if (da_port == '0 || !space) drop = 1'b1;
                else                         byte_we = 1'b1;
            end
            RxSa:   if (!in_status || !space) drop = 1'b1; else byte_we = 1'b1;
            RxLen:  if (!in_status || !space || len_bad) drop = 1'b1; else byte_we = 1'b1;
            RxPay: begin
                if (in_status) begin
                    if (pay_cnt_q == len_q || !space) drop = 1'b1;
                    else                              byte_we = 1'b1;
                end else if (pay_cnt_q == len_q && !desc_full) begin
                    commit = 1'b1;
                end else begin
                    drop = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        if (drop) begin
            rx_state_d = in_status ? RxDrop : RxIdle;
        end else if (commit) begin
            rx_state_d = RxIdle;
        end else begin
            unique case (rx_state_q)
                RxIdle:  if (byte_we) rx_state_d = RxSa;
                RxSa:    if (byte_we) rx_state_d = RxLen;
                RxLen:   if (byte_we) rx_state_d = RxPay;
                RxDrop:  if (!in_status) rx_state_d = RxIdle;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (byte_we) mem_q[tent_ptr_q] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            tent_ptr_q <= '0;
            len_q      <= '0;
            pay_cnt_q  <= '0;
            port_q     <= '0;
            ok_cnt_q   <= '0;
            drop_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            if (drop)         tent_ptr_q <= wr_ptr_q;
            else if (byte_we) tent_ptr_q <= tent_ptr_q + PtrOne;
            if (commit) wr_ptr_q <= tent_ptr_q;
            if (byte_we && rx_state_q == RxIdle) port_q <= da_port;
            if (byte_we && rx_state_q == RxLen) begin
                len_q     <= in_data;
                pay_cnt_q <= '0;
            end else if (byte_we && rx_state_q == RxPay) begin
                pay_cnt_q <= pay_cnt_q + 8'd1;
            end
            if (commit && ok_cnt_q != 16'hFFFF)  ok_cnt_q   <= ok_cnt_q + 16'd1;
            if (drop && drop_cnt_q != 16'hFFFF)  drop_cnt_q <= drop_cnt_q + 16'd1;
            busy_q <= (32'(free_bytes) < MAX_PAY + PKT_HDR_BYTES) || desc_full;
        end
    end

    assign desc_push  = commit;
    assign desc_wdata = '{port: PORT_W'(port_q),
                          total: TOTAL_W'(len_q) + TOTAL_W'(PKT_HDR_BYTES)};

    switch_desc_fifo #(
        .DEPTH (DESC_DEPTH)
    ) u_desc_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (desc_push),
        .wdata (desc_wdata),
        .pop   (desc_pop),
        .rdata (desc_head),
        .full  (desc_full),
        .empty (desc_empty),
        .count (desc_count)
    );

    assign tx_last = (tx_state_q == TxSend) && (tx_off_q == desc_head.total);

    always_ff @(posedge clk) begin
        if (rst) tx_state_q <= TxIdle;
        else     tx_state_q <= tx_state_d;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        unique case (tx_state_q)
            TxIdle: if (!desc_empty || desc_push) tx_state_d = TxReq;
            TxReq:  if (out_grant) tx_state_d = TxSend;
            TxSend: if (tx_last) begin
                tx_state_d = (desc_count > DCW'(1) || desc_push) ? TxReq : TxIdle;
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    always_comb begin
        out_req  = (tx_state_q == TxReq);
        out_port = out_req ? NUM_PORTS'(desc_head.port) : '0;
        tx_start = out_req && out_grant;
        desc_pop = tx_last;
    end

    // Byte k+1 is fetched while byte k is on the output, so the stream has no bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            tx_off_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (tx_start) begin
            out_data_q  <= mem_q[rd_ptr_q];
            out_valid_q <= 1'b1;
            out_last_q  <= (desc_head.total == TOTAL_W'(1));
            tx_off_q    <= TOTAL_W'(1);
        end else if (tx_state_q == TxSend) begin
            if (tx_last) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
                rd_ptr_q    <= rd_ptr_q + PW'(desc_head.total);
            end else begin
                out_data_q <= mem_q[rd_ptr_q + PW'(tx_off_q)];
                tx_off_q   <= tx_off_q + TOTAL_W'(1);
                out_last_q <= (tx_off_q + TOTAL_W'(1) == desc_head.total);
            end
        end
    end

    assign in_busy   = busy_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign ok_cnt    = ok_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_switch_port_rx.sv
// Scoreboard bench for switch_port_rx: a packet-level reference model predicts delivery or drop.
module tb_switch_port_rx;

    localparam int NP = 4;
    localparam int MP = 32;
    localparam int BD = 128;
    localparam int DD = 4;

    typedef logic [7:0] bq_t [$];

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      in_data;
    logic            in_status;
    logic            in_busy;
    logic [NP*8-1:0] port_addr;
    logic            out_req;
    logic [NP-1:0]   out_port;
    logic            out_grant;
    logic [7:0]      out_data;
    logic            out_valid;
    logic            out_last;
    logic [15:0]     ok_cnt;
    logic [15:0]     drop_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [8:0]  exp_bytes [$];
    logic [3:0]  exp_ports [$];
    int          exp_ok, exp_drop;
    int          grant_mode;

    switch_port_rx #(
        .NUM_PORTS  (NP),
        .MAX_PAY    (MP),
        .BUF_DEPTH  (BD),
        .DESC_DEPTH (DD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_status (in_status),
        .in_busy   (in_busy),
        .port_addr (port_addr),
        .out_req   (out_req),
        .out_port  (out_port),
        .out_grant (out_grant),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .ok_cnt    (ok_cnt),
        .drop_cnt  (drop_cnt)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Packet verdict from the framing rules: one-hot destination, or 0 when it must be dropped.
    function automatic logic [3:0] model_dest(input bq_t p);
        logic [3:0] dest = 4'd0;
        if (p.size() < 3) return 4'd0;
        for (int i = 0; i < NP; i++) begin
            if (p[0] == port_addr[8*i +: 8]) begin
                dest = 4'(1) << i;
                break;
            end
        end
        if (dest == 4'd0) return 4'd0;
        if (p[2] == 8'd0 || int'(p[2]) > MP) return 4'd0;
        if (p.size() != int'(p[2]) + 3) return 4'd0;
        return dest;
    endfunction

    task automatic send_pkt(input bq_t p, input int gap);
        logic [3:0] dest = model_dest(p);
        if (dest != 4'd0) begin
            exp_ports.push_back(dest);
            foreach (p[i]) exp_bytes.push_back({i == p.size() - 1, p[i]});
            exp_ok++;
        end else begin
            exp_drop++;
        end
        foreach (p[i]) begin
            in_status = 1'b1;
            in_data   = p[i];
            @(posedge clk); #1;
        end
        in_status = 1'b0;
        in_data   = 8'($urandom);
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_not_busy();
        for (int c = 0; c < 3000 && in_busy; c++) begin
            @(posedge clk); #1;
        end
        if (in_busy) check("busy_timeout", in_busy, 1'b0);
    endtask

    task automatic wait_drain(input string tag);
        for (int c = 0; c < 6000; c++) begin
            if (exp_bytes.size() == 0 && exp_ports.size() == 0 && !out_valid && !out_req) break;
            @(posedge clk); #1;
        end
        check({tag, "_bytes_left"}, exp_bytes.size(), 0);
        check({tag, "_ports_left"}, exp_ports.size(), 0);
        check({tag, "_ok_cnt"}, ok_cnt, exp_ok);
        check({tag, "_drop_cnt"}, drop_cnt, exp_drop);
    endtask

    function automatic bq_t make_pkt(input logic [7:0] da, input int len, input int n_pay);
        bq_t p = '{da, 8'($urandom), 8'(len)};
        for (int i = 0; i < n_pay; i++) p.push_back(8'($urandom));
        return p;
    endfunction

    function automatic bq_t rand_pkt();
        logic [7:0] da;
        int         len, n_pay, k;
        bq_t        p;
        k     = $urandom_range(0, NP - 1);
        da    = ($urandom_range(0, 4) == 0) ? 8'($urandom) : port_addr[8*k +: 8];
        len   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(1, MP);
        n_pay = ($urandom_range(0, 3) == 0) ? $urandom_range(0, MP + 3) : len;
        if (n_pay > MP + 3) n_pay = $urandom_range(0, MP + 3);
        p = make_pkt(da, len, n_pay);
        if ($urandom_range(0, 15) == 0) begin
            k = $urandom_range(1, 2);
            while (p.size() > k) void'(p.pop_back());
        end
        return p;
    endfunction

    initial begin
        out_grant = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (grant_mode)
                0:       out_grant = 1'b0;
                1:       out_grant = 1'b1;
                default: out_grant = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on each accepted request and each output byte.
    bit         mon_burst = 1'b0;
    bit         mon_hold  = 1'b0;
    logic [3:0] mon_port;
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_burst = 1'b0;
                mon_hold  = 1'b0;
            end else begin
                if (mon_burst || out_valid) begin
                    if (!out_valid) begin
                        check("stream_gap", out_valid, 1'b1);
                        mon_burst = 1'b0;
                    end else if (!mon_burst || exp_bytes.size() == 0) begin
                        check("unexpected_byte", out_valid, 1'b0);
                    end else begin
                        e = exp_bytes.pop_front();
                        check("out_data", out_data, e[7:0]);
                        check("out_last", out_last, e[8]);
                        if (e[8]) mon_burst = 1'b0;
                    end
                end
                if (mon_hold) begin
                    check("req_held", out_req, 1'b1);
                    check("port_held", out_port, mon_port);
                end
                mon_hold = 1'b0;
                if (out_req) begin
                    if (out_grant) begin
                        check("req_expected", exp_ports.size() != 0, 1'b1);
                        if (exp_ports.size() != 0) check("out_port", out_port, exp_ports.pop_front());
                        mon_burst = 1'b1;
                    end else begin
                        mon_hold = 1'b1;
                        mon_port = out_port;
                    end
                end
            end
        end
    end

    initial begin
        bq_t p;
        int  n_sent, n_exp, free, found;

        rst        = 1'b1;
        in_status  = 1'b0;
        in_data    = 8'd0;
        port_addr  = 32'h3020_1000;
        grant_mode = 1;
        exp_ok     = 0;
        exp_drop   = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_out_req", out_req, 1'b0);
        check("rst_out_port", out_port, 4'd0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_in_busy", in_busy, 1'b0);
        check("rst_ok_cnt", ok_cnt, 16'd0);
        check("rst_drop_cnt", drop_cnt, 16'd0);
        repeat (2) begin @(posedge clk); #1; end

        p = '{8'h20, 8'h01, 8'h03, 8'hAA, 8'hBB, 8'hCC};
        send_pkt(p, 3);
        wait_drain("basic");

        p = '{8'h55, 8'h01, 8'h02, 8'h11, 8'h22};
        send_pkt(p, 2);
        p = '{8'h00, 8'h07, 8'h01, 8'h5A};
        send_pkt(p, 2);
        wait_drain("bad_da");

        p = '{8'h10, 8'h01, 8'h04, 8'h01, 8'h02};
        send_pkt(p, 2);
        p = '{8'h30, 8'h01, 8'h02, 8'h0A, 8'h0B, 8'h0C};
        send_pkt(p, 2);
        p = '{8'h30, 8'h02, 8'h00};
        send_pkt(p, 2);
        p = '{8'h30, 8'h02, 8'd33, 8'h01};
        send_pkt(p, 2);
        wait_drain("runt_giant");

        // Grant withheld: fill with max-size packets until back-pressure appears.
        free  = BD - 1;
        n_exp = 0;
        while (!(free < MP + 3 || n_exp == DD)) begin
            free -= MP + 3;
            n_exp++;
        end
        grant_mode = 0;
        n_sent     = 0;
        repeat (2) begin @(posedge clk); #1; end
        for (int k = 0; k < 10; k++) begin
            if (in_busy) break;
            send_pkt(make_pkt(port_addr[8*(k % NP) +: 8], MP, MP), 2);
            n_sent++;
        end
        check("hold_pkts_before_busy", n_sent, n_exp);
        check("hold_busy_set", in_busy, 1'b1);
        check("hold_req_up", out_req, 1'b1);
        check("hold_no_drops", drop_cnt, exp_drop);
        grant_mode = 1;
        wait_drain("hold");

        // Second packet commits while the first streams; its request must follow immediately.
        send_pkt(make_pkt(8'h10, MP, MP), 2);
        send_pkt(make_pkt(8'h30, 2, 2), 2);
        found = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (out_valid && out_last) begin
                found = 1;
                break;
            end
        end
        check("b2b_first_last_seen", found, 1);
        @(negedge clk);
        check("b2b_req_next_cycle", out_req, 1'b1);
        @(posedge clk); #1;
        wait_drain("b2b");

        grant_mode = 2;
        for (int k = 0; k < 120; k++) begin
            wait_not_busy();
            send_pkt(rand_pkt(), $urandom_range(2, 4));
        end
        grant_mode = 1;
        wait_drain("random");

        // Reset in mid-payload; bytes still streaming after reset must be ignored until a gap.
        p = make_pkt(8'h20, 10, 10);
        for (int i = 0; i < 6; i++) begin
            in_status = 1'b1;
            in_data   = p[i];
            @(posedge clk); #1;
        end
        rst       = 1'b1;
        port_addr = 32'h1020_1000;
        in_data   = p[6];
        repeat (2) begin @(posedge clk); #1; end
        check("midrst_out_req", out_req, 1'b0);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_ok_cnt", ok_cnt, 16'd0);
        check("midrst_drop_cnt", drop_cnt, 16'd0);
        check("midrst_in_busy", in_busy, 1'b0);
        rst      = 1'b0;
        exp_ok   = 0;
        exp_drop = 0;
        for (int i = 7; i < p.size(); i++) begin
            in_data = p[i];
            @(posedge clk); #1;
        end
        in_status = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("resync_no_drop", drop_cnt, 16'd0);
        send_pkt(make_pkt(8'h10, 5, 5), 2);
        wait_drain("after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
